tlb_miss_walker: RTL and testbench

- Hardware page-table walker serving the instruction and data TLBs on a translation miss.
- Accepts a missed {segment, offset} and hashes it into the in-memory page table.
- Walks the collision chain over a simple memory-read handshake.
- Returns either a TLB fill (tag + data write) or a fault; one walk at a time.

---
 rtl/tlb_miss_walker.sv | 220 ++++++++++++++++++++++
 tb/tb_tlb_miss_walker.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_miss_walker.sv
// Hashed page-table walker: turns a TLB miss into a chain walk over a simple
// read handshake and returns either a TLB fill or a fault code.
module tlb_miss_walker #(
    parameter int WORD_LENGTH   = 32,
    parameter int HASH_BITS     = 10,
    parameter int MAX_CHAIN     = 8,
    parameter int TLB_TAG_WIDTH = 20
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 missReq,
    input  logic [WORD_LENGTH-1:0]               missSeg,
    input  logic [WORD_LENGTH-1:0]               missOfs,
    input  logic [WORD_LENGTH-1:0]               ptBase,
    output logic                                 busy,
    output logic                                 memReq,
    output logic [WORD_LENGTH-1:0]               memAdr,
    input  logic                                 memAck,
    input  logic [WORD_LENGTH-1:0]               memData,
    output logic                                 tlbWrEn,
    output logic [WORD_LENGTH+TLB_TAG_WIDTH-1:0] tlbWrTag,
    output logic [WORD_LENGTH-1:0]               tlbWrData,
    output logic                                 done,
    output logic                                 fault,
    output logic [1:0]                           faultCode
);

    localparam int CNT_W = $clog2(MAX_CHAIN + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HASH    = 3'd1,
        RD_SEG  = 3'd2,
        RD_VPN  = 3'd3,
        RD_INFO = 3'd4,
        RD_NEXT = 3'd5,
        FILL    = 3'd6,
        FAULT   = 3'd7
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [WORD_LENGTH-1:0]          r_entry;
    logic [WORD_LENGTH-1:0]          w_entry_nxt;
    logic [CNT_W-1:0]                r_cnt;
    logic [CNT_W-1:0]                w_cnt_nxt;
    logic [1:0]                      w_code_nxt;
    logic                            w_rd_nxt;
    logic [WORD_LENGTH-1:0]          r_seg;
    logic [TLB_TAG_WIDTH-1:0]        r_vpn;
    logic [WORD_LENGTH-5:0]          r_ptbase;
    logic [HASH_BITS-1:0]            w_idx;
    logic [WORD_LENGTH-1:0]          w_hash_adr;
    logic                            w_unused;

    logic                                 r_busy;
    logic                                 r_mem_req;
    logic [WORD_LENGTH-1:0]               r_mem_adr;
    logic                                 r_tlb_wr_en;
    logic [WORD_LENGTH+TLB_TAG_WIDTH-1:0] r_tlb_wr_tag;
    logic [WORD_LENGTH-1:0]               r_tlb_wr_data;
    logic                                 r_done;
    logic                                 r_fault;
    logic [1:0]                           r_fault_code;

    // Byte offset of the entry word fetched in each read state.
    function automatic logic [WORD_LENGTH-1:0] rd_ofs(input state_t s);
        case (s)
            RD_SEG:  rd_ofs = WORD_LENGTH'(0);
            RD_VPN:  rd_ofs = WORD_LENGTH'(4);
            RD_INFO: rd_ofs = WORD_LENGTH'(8);
            RD_NEXT: rd_ofs = WORD_LENGTH'(12);
            default: rd_ofs = WORD_LENGTH'(0);
        endcase
    endfunction

    assign w_idx      = r_seg[HASH_BITS-1:0] ^ r_vpn[HASH_BITS-1:0];
    assign w_hash_adr = {r_ptbase, 4'b0000} + (WORD_LENGTH'(w_idx) << 4);
    assign w_unused   = &{1'b0, missOfs[WORD_LENGTH-TLB_TAG_WIDTH-1:0], ptBase[3:0]};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, chain pointer and counter decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_entry_nxt = r_entry;
        w_cnt_nxt   = r_cnt;
        w_code_nxt  = 2'b00;
        case (r_state)
            IDLE: begin
                if (missReq) begin
                    w_state_nxt = HASH;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            HASH: begin
                w_entry_nxt = w_hash_adr;
                w_state_nxt = RD_SEG;
            end
            RD_SEG: begin
                if (memAck) begin
                    if (memData == r_seg) begin
                        w_state_nxt = RD_VPN;
                    end else begin
                        w_state_nxt = RD_NEXT;
                    end
                end else begin
                    w_state_nxt = RD_SEG;
                end
            end
            RD_VPN: begin
                if (memAck) begin
                    if (memData[WORD_LENGTH-1] && (memData[TLB_TAG_WIDTH-1:0] == r_vpn)) begin
                        w_state_nxt = RD_INFO;
                    end else begin
                        w_state_nxt = RD_NEXT;
                    end
                end else begin
                    w_state_nxt = RD_VPN;
                end
            end
            RD_INFO: begin
                if (memAck) begin
                    w_state_nxt = FILL;
                end else begin
                    w_state_nxt = RD_INFO;
                end
            end
            RD_NEXT: begin
                // End of chain outranks misalignment, which outranks depth.
                if (memAck) begin
                    if (memData == WORD_LENGTH'(0)) begin
                        w_state_nxt = FAULT;
                        w_code_nxt  = 2'b01;
                    end else if (memData[3:0] != 4'h0) begin
                        w_state_nxt = FAULT;
                        w_code_nxt  = 2'b11;
                    end else if (r_cnt == CNT_W'(MAX_CHAIN)) begin
                        w_state_nxt = FAULT;
                        w_code_nxt  = 2'b10;
                    end else begin
                        w_state_nxt = RD_SEG;
                        w_entry_nxt = memData;
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_state_nxt = RD_NEXT;
                end
            end
            FILL:    w_state_nxt = IDLE;
            FAULT:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        w_rd_nxt = (w_state_nxt == RD_SEG) || (w_state_nxt == RD_VPN) ||
                   (w_state_nxt == RD_INFO) || (w_state_nxt == RD_NEXT);
    end

    // Walk context and outputs, registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_entry       <= '0;
            r_cnt         <= '0;
            r_seg         <= '0;
            r_vpn         <= '0;
            r_ptbase      <= '0;
            r_busy        <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_adr     <= '0;
            r_tlb_wr_en   <= 1'b0;
            r_tlb_wr_tag  <= '0;
            r_tlb_wr_data <= '0;
            r_done        <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_code  <= 2'b00;
        end else begin
            r_entry <= w_entry_nxt;
            r_cnt   <= w_cnt_nxt;
            if ((r_state == IDLE) && missReq) begin
                r_seg    <= missSeg;
                r_vpn    <= missOfs[WORD_LENGTH-1 -: TLB_TAG_WIDTH];
                r_ptbase <= ptBase[WORD_LENGTH-1:4];
            end
            r_busy    <= (w_state_nxt != IDLE);
            r_mem_req <= w_rd_nxt;
            if (w_rd_nxt) begin
                r_mem_adr <= w_entry_nxt + rd_ofs(w_state_nxt);
            end
            r_done      <= (w_state_nxt == FILL) || (w_state_nxt == FAULT);
            r_fault     <= (w_state_nxt == FAULT);
            r_tlb_wr_en <= (w_state_nxt == FILL);
            if (w_state_nxt == FILL) begin
                r_tlb_wr_tag  <= {r_seg, r_vpn};
                r_tlb_wr_data <= memData;
                r_fault_code  <= 2'b00;
            end else if (w_state_nxt == FAULT) begin
                r_fault_code  <= w_code_nxt;
            end
        end
    end

    assign busy      = r_busy;
    assign memReq    = r_mem_req;
    assign memAdr    = r_mem_adr;
    assign tlbWrEn   = r_tlb_wr_en;
    assign tlbWrTag  = r_tlb_wr_tag;
    assign tlbWrData = r_tlb_wr_data;
    assign done      = r_done;
    assign fault     = r_fault;
    assign faultCode = r_fault_code;

endmodule

// File: tb/tb_tlb_miss_walker.sv
// Directed and randomized walks of tlb_miss_walker against a sparse-memory
// reference walk computed straight from the page-table rules.
module tb_tlb_miss_walker;

    logic        clk = 1'b0;
    logic        rst;
    logic        missReq;
    logic [31:0] missSeg, missOfs, ptBase;
    logic        busy, memReq, memAck;
    logic [31:0] memAdr, memData, tlbWrData;
    logic        tlbWrEn, done, fault;
    logic [51:0] tlbWrTag;
    logic [1:0]  faultCode;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_adr [$];
    logic [51:0] last_tag;
    logic [31:0] last_data;

    tlb_miss_walker dut (
        .clk(clk), .rst(rst), .missReq(missReq), .missSeg(missSeg), .missOfs(missOfs),
        .ptBase(ptBase), .busy(busy), .memReq(memReq), .memAdr(memAdr), .memAck(memAck),
        .memData(memData), .tlbWrEn(tlbWrEn), .tlbWrTag(tlbWrTag), .tlbWrData(tlbWrData),
        .done(done), .fault(fault), .faultCode(faultCode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        else return 32'd0;
    endfunction

    task automatic put(input logic [31:0] a, input logic [31:0] w0, w1, w2, w3);
        mem[a] = w0; mem[a + 32'd4] = w1; mem[a + 32'd8] = w2; mem[a + 32'd12] = w3;
    endtask

    function automatic logic [31:0] bucket(input logic [31:0] seg, ofs, base);
        logic [31:0] idx;
        idx = {22'd0, seg[9:0] ^ ofs[21:12]};
        return {base[31:4], 4'h0} + (idx << 4);
    endfunction

    // Reference walk: fills exp_adr with the word addresses read, returns the outcome.
    function automatic void ref_walk(input logic [31:0] seg, ofs, base,
                                     output bit flt, output logic [1:0] code, output logic [31:0] info);
        logic [31:0] e, w, nxt;
        logic [19:0] vpn;
        vpn = ofs[31:12];
        e = bucket(seg, ofs, base);
        flt = 1'b0; code = 2'b00; info = 32'd0;
        exp_adr.delete();
        for (int hops = 1; hops <= 8; hops++) begin
            exp_adr.push_back(e);
            if (rd(e) == seg) begin
                exp_adr.push_back(e + 32'd4);
                w = rd(e + 32'd4);
                if (w[31] && w[19:0] == vpn) begin
                    exp_adr.push_back(e + 32'd8);
                    info = rd(e + 32'd8);
                    return;
                end
            end
            exp_adr.push_back(e + 32'd12);
            nxt = rd(e + 32'd12);
            if (nxt == 32'd0) begin flt = 1'b1; code = 2'b01; return; end
            if (nxt[3:0] != 4'h0) begin flt = 1'b1; code = 2'b11; return; end
            if (hops == 8) begin flt = 1'b1; code = 2'b10; return; end
            e = nxt;
        end
    endfunction

    task automatic run_walk(input logic [31:0] seg, ofs, base, input int wt);
        bit flt;
        logic [1:0] code;
        logic [31:0] info, hold_adr, ea;
        int exp_done, exp_reads, nreads, cyc, waitc;
        bit got_done;
        ref_walk(seg, ofs, base, flt, code, info);
        exp_reads = exp_adr.size();
        exp_done  = 2 + exp_reads * (wt + 1);
        missSeg = seg; missOfs = ofs; ptBase = base; missReq = 1'b1;
        cyc = 0; waitc = 0; nreads = 0; got_done = 1'b0; hold_adr = 32'd0;
        while (!got_done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            memAck = 1'b0;
            if (cyc == 2) begin
                ptBase = $urandom; missSeg = $urandom; missOfs = $urandom;
            end
            if (cyc == 1) chk("busy_start", busy, 1);
            if (waitc > 0) begin
                chk("req_held", memReq, 1);
                chk("adr_stable", memAdr, hold_adr);
            end
            if (memReq) begin
                if (waitc == 0) begin
                    hold_adr = memAdr;
                    nreads++;
                    if (exp_adr.size() > 0) begin
                        ea = exp_adr.pop_front();
                        chk("rd_adr", memAdr, ea);
                    end
                end
                if (waitc == wt) begin
                    memAck = 1'b1; memData = rd(memAdr); waitc = 0;
                end else begin
                    waitc++;
                end
            end else begin
                waitc = 0;
            end
            if (done) begin
                got_done = 1'b1;
                missReq = 1'b0;
                chk("done_cycle", cyc, exp_done);
                chk("fault", fault, flt);
                chk("tlbWrEn", tlbWrEn, !flt);
                chk("faultCode", faultCode, flt ? code : 2'b00);
                if (!flt) begin
                    last_tag  = {seg, ofs[31:12]};
                    last_data = info;
                end
                chk("tlbWrTag", tlbWrTag, last_tag);
                chk("tlbWrData", tlbWrData, last_data);
            end else if (tlbWrEn) begin
                chk("stray_tlbWrEn", tlbWrEn, 0);
            end
        end
        chk("done_seen", got_done, 1);
        chk("read_count", nreads, exp_reads);
        missReq = 1'b0;
        memAck  = 1'b0;
        @(posedge clk); #1;
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_req", memReq, 0);
    endtask

    initial begin
        logic [31:0] s, o, b, e, a, nx, w1;
        int len, kind;
        rst = 1'b0; missReq = 1'b0; missSeg = 32'd0; missOfs = 32'd0; ptBase = 32'd0;
        memAck = 1'b0; memData = 32'd0;
        last_tag = 52'd0; last_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_memReq", memReq, 0);
        chk("rst_memAdr", memAdr, 0);
        chk("rst_tlbWrEn", tlbWrEn, 0);
        chk("rst_tag", tlbWrTag, 0);
        chk("rst_data", tlbWrData, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_code", faultCode, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Bucket hit at idx 6.
        mem.delete();
        put(32'h0001_0060, 32'h3, 32'h8000_0005, 32'hAB00_1234, 32'h0);
        run_walk(32'h3, 32'h0000_5123, 32'h0001_0000, 0);
        // Same walk with three wait cycles per read.
        run_walk(32'h3, 32'h0000_5123, 32'h0001_000F, 3);

        // Chain hit through a segment mismatch.
        mem.delete();
        put(32'h0001_0060, 32'h7, 32'h8000_0005, 32'h0, 32'h0002_0000);
        put(32'h0002_0000, 32'h3, 32'h8000_0005, 32'h55AA_77EE, 32'h0);
        run_walk(32'h3, 32'h0000_5123, 32'h0001_0000, 0);

        // Chain end after an invalid VPN word.
        mem.delete();
        put(32'h0001_0060, 32'h3, 32'h0000_0005, 32'h1, 32'h0);
        run_walk(32'h3, 32'h0000_5123, 32'h0001_0000, 0);

        // Circular chain hits the depth limit.
        mem.delete();
        put(32'h0001_0060, 32'h9, 32'h8000_0005, 32'h0, 32'h0001_0060);
        run_walk(32'h3, 32'h0000_5123, 32'h0001_0000, 1);

        // Misaligned next pointer.
        mem.delete();
        put(32'h0001_0060, 32'h9, 32'h8000_0005, 32'h0, 32'h0002_0004);
        run_walk(32'h3, 32'h0000_5123, 32'h0001_0000, 0);

        // Reset while the VPN word is being requested.
        mem.delete();
        put(32'h0001_0060, 32'h3, 32'h8000_0005, 32'hCAFE_0001, 32'h0);
        missSeg = 32'h3; missOfs = 32'h0000_5123; ptBase = 32'h0001_0000; missReq = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        memAck = 1'b1; memData = 32'h3;
        @(posedge clk); #1;
        memAck = 1'b0; missReq = 1'b0;
        chk("rd_vpn_req", memReq, 1);
        chk("rd_vpn_adr", memAdr, 32'h0001_0064);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_req", memReq, 0);
        chk("rst_mid_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        last_tag = 52'd0; last_data = 32'd0;
        memAck = 1'b1; memData = 32'h8000_0005;
        @(posedge clk); #1;
        memAck = 1'b0;
        chk("late_ack_busy", busy, 0);
        chk("late_ack_req", memReq, 0);
        chk("late_ack_done", done, 0);
        run_walk(32'h3, 32'h0000_5123, 32'h0001_0000, 0);

        // Randomized chains of mixed mismatch kinds.
        for (int t = 0; t < 40; t++) begin
            mem.delete();
            s = $urandom; o = $urandom; b = $urandom;
            if (t % 3 == 0) s[31:10] = 22'd0;
            e = bucket(s, o, b);
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                kind = $urandom_range(0, 3);
                if (i == len - 1) begin
                    nx = ($urandom_range(0, 3) == 0) ? {b[31:4] ^ 28'h5A5A5A5, 4'h8} : 32'd0;
                end else begin
                    do begin
                        a = $urandom; nx = {a[31:4], 4'h0};
                    end while (mem.exists(nx) || nx == e || nx == 32'd0);
                end
                a = $urandom;
                case (kind)
                    0:       w1 = {1'b1, a[10:0], o[31:12]};
                    1:       w1 = {1'b0, a[10:0], o[31:12]};
                    2:       w1 = {1'b1, a[10:0], o[31:12] ^ 20'h00001};
                    default: w1 = {1'b1, a[10:0], o[31:12]};
                endcase
                put(e, (kind == 0) ? (s ^ 32'h1) : s, w1, $urandom, nx);
                e = nx;
            end
            run_walk(s, o, b, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
